// File: rtl/spi_flash_pkg.sv
// Shared state encoding, opcodes and frame field widths for the SPI NOR flash read controller.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS  = 16;

  // Word address to flash byte address: 16-bit words live at even byte offsets.
  function automatic logic [ADDR_BITS-1:0] byte_addr(input logic [15:0] word_addr);
    return {7'b0, word_addr, 1'b0};
  endfunction

  function automatic logic [5:0] last_bit(input state_e st);
    logic [5:0] result;
    case (st)
      ST_CMD:   result = 6'(CMD_BITS - 1);
      ST_ADDR:  result = 6'(ADDR_BITS - 1);
      ST_DUMMY: result = 6'(DUMMY_BITS - 1);
      default:  result = 6'(DATA_BITS - 1);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/spi_flash_ctrl_clk_div.sv
// SCLK generator for spi_flash_ctrl: SCLK_HALF-cycle half periods, low phase first,
// with single-cycle strobes on the clk edge that raises or lowers sclk.
module spi_clk_div #(
  parameter int unsigned SCLK_HALF = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic run_in,
  output logic sclk_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int unsigned CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          half_done;

  assign half_done = run_in && (cnt_q == CNT_LAST);
  assign rise_out  = half_done && !phase_q;
  assign fall_out  = half_done && phase_q;
  assign sclk_out  = phase_q;

  // Held at the start of a low phase while idle so the first bit begins cleanly.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_in) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (half_done) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_flash_ctrl.sv
// Read-only SPI NOR flash controller (mode 0): one READ frame per word request.
// Define SPI_FLASH_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_ctrl #(
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  output logic        sclk_out,
  output logic        cs_out,
  output logic        mosi_out,
  input  logic        miso_in,
  input  logic [15:0] addr_in,
  input  logic        addr_valid_in,
  output logic [15:0] data_out,
  output logic        data_valid_out,
  output logic        busy_out
);

  import spi_flash_pkg::*;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_OPCODE = CMD_FAST_READ;
  localparam state_e     AFTER_ADDR = ST_DUMMY;
`else
  localparam logic [7:0] CMD_OPCODE = CMD_READ;
  localparam state_e     AFTER_ADDR = ST_DATA;
`endif

  localparam int unsigned   GW       = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam int            TX_BITS  = CMD_BITS + ADDR_BITS;

  state_e               state_q, state_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [TX_BITS-1:0]   tx_q, tx_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 cs_q, cs_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 sclk_rise, sclk_fall;

  spi_clk_div #(
    .SCLK_HALF(SCLK_HALF)
  ) u_clk_div (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .run_in  (!cs_q),
    .sclk_out(sclk_out),
    .rise_out(sclk_rise),
    .fall_out(sclk_fall)
  );

  // MOSI is the MSB of the outgoing shift register; zeros shifted in behind
  // the address keep it low through the dummy and data phases.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_d    = data_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (addr_valid_in) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
          tx_d      = {CMD_OPCODE, byte_addr(addr_in)};
          cs_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        if (sclk_rise && (state_q == ST_DATA)) begin
          rx_d = {rx_q[DATA_BITS-2:0], miso_in};
        end
        if (sclk_fall) begin
          tx_d      = {tx_q[TX_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == last_bit(state_q)) begin
            bit_cnt_d = '0;
            case (state_q)
              ST_CMD:   state_d = ST_ADDR;
              ST_ADDR:  state_d = AFTER_ADDR;
              ST_DUMMY: state_d = ST_DATA;
              default: begin
                state_d   = ST_GAP;
                cs_d      = 1'b1;
                data_d    = rx_q;
                valid_d   = 1'b1;
                gap_cnt_d = '0;
              end
            endcase
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        tx_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_q    <= '0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_q    <= data_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign cs_out         = cs_q;
  assign mosi_out       = tx_q[TX_BITS-1];
  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Self-checking bench for spi_flash_ctrl with a behavioural SPI flash model.
// Honours SPI_FLASH_FAST_READ_EN the same way the design does.
module tb_spi_flash_ctrl;

  localparam int H = 2;
  localparam int G = 4;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int         N       = 56;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam int         N       = 48;
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif
  localparam int PRE = N - 16;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        sclk_out, cs_out, mosi_out;
  logic        miso_in = 1'b0;
  logic [15:0] addr_in = '0;
  logic        addr_valid_in = 1'b0;
  logic [15:0] data_out;
  logic        data_valid_out, busy_out;

  spi_flash_ctrl #(
    .SCLK_HALF(H),
    .CS_GAP   (G)
  ) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .sclk_out      (sclk_out),
    .cs_out        (cs_out),
    .mosi_out      (mosi_out),
    .miso_in       (miso_in),
    .addr_in       (addr_in),
    .addr_valid_in (addr_valid_in),
    .data_out      (data_out),
    .data_valid_out(data_valid_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dv_count = 0;
  int high_run = 0;
  int last_gap = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Flash contents: one pinned word plus a scrambled pattern everywhere else.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] r;
    if (a == 16'h1234) r = 16'h8086;
    else               r = (a * 16'd40503) ^ 16'h5A5A;
    return r;
  endfunction

  // Flash model: records MOSI on rising SCLK, drives MISO after falling SCLK.
  logic [63:0] frame_bits = '0;
  int          nbits = 0;
  int          sclk_rises = 0;
  logic [15:0] resp = '0;
  logic        sclk_prev = 1'b0;
  logic        frame_active = 1'b0;

  always @(cs_out or sclk_out) begin
    logic rose, fell;
    rose      = (sclk_out === 1'b1) && !sclk_prev;
    fell      = (sclk_out === 1'b0) && sclk_prev;
    sclk_prev = (sclk_out === 1'b1);
    if (rose) sclk_rises++;
    if (cs_out !== 1'b0) begin
      frame_active = 1'b0;
    end else if (!frame_active) begin
      frame_active = 1'b1;
      frame_bits   = '0;
      nbits        = 0;
      miso_in      = 1'b0;
    end else if (rose) begin
      frame_bits = {frame_bits[62:0], mosi_out};
      nbits++;
      if (nbits == 32) resp = mem_word(frame_bits[16:1]);
    end else if (fell && nbits >= PRE && nbits < N) begin
      miso_in = resp[15 - (nbits - PRE)];
    end
  end

  always @(negedge clk_in) begin
    if (data_valid_out === 1'b1) dv_count++;
    if (cs_out === 1'b1) high_run++;
    else if (high_run > 0) begin
      last_gap = high_run;
      high_run = 0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Issues one request at the current negedge and checks the whole frame.
  task automatic apply_stimulus(input logic [15:0] a, input logic [23:0] exp24,
                                input logic [15:0] expd, input int extra_at);
    int t0, tv, dv_before;
    logic [7:0] cmd_v;
    cmd_v         = EXP_CMD;
    dv_before     = dv_count;
    addr_in       = a;
    addr_valid_in = 1'b1;
    @(posedge clk_in); #1;
    t0 = cyc;
    check_output("t0_busy", busy_out, 1);
    check_output("t0_cs", cs_out, 0);
    check_output("t0_mosi", mosi_out, cmd_v[7]);
    @(negedge clk_in);
    addr_valid_in = 1'b0;
    addr_in       = 16'($urandom);
    while (data_valid_out !== 1'b1 && (cyc - t0) < 2 * N * H + 50) begin
      if (extra_at > 0 && (cyc - t0) == extra_at) begin
        addr_valid_in = 1'b1;
        addr_in       = 16'hBEEF;
      end else begin
        addr_valid_in = 1'b0;
      end
      @(negedge clk_in);
    end
    addr_valid_in = 1'b0;
    check_output("dv_latency", cyc - t0, 2 * N * H);
    check_output("data_out", data_out, expd);
    check_output("cs_at_dv", cs_out, 1);
    check_output("sclk_at_dv", sclk_out, 0);
    tv = cyc;
    @(negedge clk_in);
    check_output("dv_one_cycle", data_valid_out, 0);
    while (busy_out === 1'b1 && (cyc - tv) < G + 20) @(negedge clk_in);
    check_output("busy_fall", cyc - tv, G);
    check_output("frame_len", nbits, N);
    check_output("frame_cmd", frame_bits[N-1 -: 8], EXP_CMD);
    check_output("frame_addr", frame_bits[N-9 -: 24], exp24);
    check_output("mosi_tail_zero", frame_bits[N-33:0], 0);
    check_output("dv_pulses", dv_count - dv_before, 1);
    check_output("cs_gap_ok", last_gap >= G, 1);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [23:0] exp_addr24;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, dv_before;
    logic [15:0] a;

    vecs[0] = '{16'h1234, 24'h002468, 16'h8086};
    vecs[1] = '{16'hFFFF, 24'h01FFFE, mem_word(16'hFFFF)};
    vecs[2] = '{16'h0000, 24'h000000, mem_word(16'h0000)};
    vecs[3] = '{16'h0001, 24'h000002, mem_word(16'h0001)};
    vecs[4] = '{16'h8000, 24'h010000, mem_word(16'h8000)};

    repeat (10) @(negedge clk_in);
    check_output("rst_cs", cs_out, 1);
    check_output("rst_sclk", sclk_out, 0);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_output("rst_sclk_after", sclk_out, 0);
    check_output("rst_cs_after", cs_out, 1);
    check_output("rst_mosi", mosi_out, 0);
    check_output("rst_data", data_out, 0);
    check_output("rst_dv", data_valid_out, 0);
    check_output("rst_busy", busy_out, 0);
    check_output("rst_no_sclk", sclk_rises, 0);

    // Table vectors run back to back (0xFFFF then 0x0000 at minimum spacing).
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].exp_addr24, vecs[i].exp_data, 0);
    end

    // A second strobe while busy must be dropped, not queued.
    apply_stimulus(16'h1234, 24'h002468, 16'h8086, 50);
    repeat (6) @(negedge clk_in);
    check_output("drop_no_restart_cs", cs_out, 1);
    check_output("drop_no_restart_busy", busy_out, 0);
    check_output("drop_held_data", data_out, 16'h8086);

    // Asynchronous abort in the middle of an SCLK high phase.
    dv_before     = dv_count;
    addr_in       = 16'h1234;
    addr_valid_in = 1'b1;
    @(posedge clk_in); #1;
    t0 = cyc;
    @(negedge clk_in);
    addr_valid_in = 1'b0;
    while ((cyc - t0) < 102) @(negedge clk_in);
    check_output("abort_sclk_high_before", sclk_out, 1);
    reset_in = 1'b0;
    #1;
    check_output("abort_cs", cs_out, 1);
    check_output("abort_sclk", sclk_out, 0);
    check_output("abort_busy", busy_out, 0);
    check_output("abort_dv", data_valid_out, 0);
    repeat (3) @(negedge clk_in);
    reset_in = 1'b1;
    repeat (250) @(negedge clk_in);
    check_output("abort_no_valid", dv_count - dv_before, 0);
    check_output("abort_data_cleared", data_out, 0);
    apply_stimulus(16'h0001, 24'h000002, mem_word(16'h0001), 0);

    // Random requests against the arithmetic address/memory model.
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
      apply_stimulus(a, 24'(a) * 24'd2, mem_word(a),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 180)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_ctrl.md
# spi_flash_ctrl

Read-only SPI NOR flash controller that turns a 16-bit word-address request from the system bus into one SPI READ transaction and returns one 16-bit word. It sits between the CPU instruction/data fetch path and an external serial flash. It uses SPI mode 0 with a single chip select and is half-duplex.

## Interface
- `SCLK_HALF`, default 2: clk_in cycles per SCLK half-period (≥1); SCLK = clk/(2·SCLK_HALF).
- `CS_GAP`, default 4: minimum clk_in cycles cs_out stays high between transactions (≥1).
- `clk_in`  in  1  system clock; all logic on rising edge.
- `reset_in`  in  1  asynchronous, active-low reset.
- `sclk_out`  out  1  SPI clock, idles low.
- `cs_out`  out  1  chip select, active-low.
- `mosi_out`  out  1  controller→flash serial data.
- `miso_in`  in  1  flash→controller serial data.
- `addr_in`  in  16  word address, sampled with addr_valid_in.
- `addr_valid_in`  in  1  single-cycle request strobe.
- `data_out`  out  16  last word read; held until the next completion.
- `data_valid_out`  out  1  one-cycle pulse when data_out updates.
- `busy_out`  out  1  transaction in progress; requests ignored.

## Operation
- Frame: command byte, 24-bit byte address = {7'b0, addr_in, 1'b0}, then 16 data bits. All fields are MSB first.
- Command byte is 0x03 (READ).
- The received word is shifted MSB first. The first bit received is data_out[15].
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → [DUMMY (8 bits)] → DATA (16 bits) → GAP → IDLE.
- IDLE: when addr_valid_in=1 and busy_out=0, latch the address, assert busy_out and cs_out=0, and drive mosi_out with cmd[7].
- addr_valid_in is ignored while busy_out=1. The request is dropped, not queued.
- Bit timing: each bit has a low phase of SCLK_HALF cycles, then a high phase of SCLK_HALF cycles.
  - mosi_out changes only on the clk edge that lowers sclk, or on the edge that asserts cs_out.
  - miso_in is sampled on the clk edge that raises sclk.
- During DATA, mosi_out is driven 0.
- After the final falling SCLK edge:
  - cs_out goes 1 and sclk_out stays 0.
  - data_out is loaded and data_valid_out pulses for one cycle.
  - The block enters GAP.
- GAP lasts CS_GAP cycles. busy_out then clears in IDLE.
- Bit counters are 6 bits. State transitions occur on counter terminal values, never on wrap.

## Timing
- Reset values: sclk_out=0, cs_out=1, mosi_out=0, data_out=0, data_valid_out=0, busy_out=0, state IDLE.
- Reset asserted mid-transaction aborts immediately: cs_out=1, sclk_out=0, and no data_valid_out pulse.
- Edge numbering: T0 is the clk edge that accepts the request. busy_out=1 and cs_out=0 take effect from T0.
- Bit k (0-based):
  - sclk rises at T0+2k·SCLK_HALF+SCLK_HALF.
  - sclk falls at T0+2(k+1)·SCLK_HALF.
- Transaction length is N=48 bits, or 56 with fast read.
- data_valid_out=1 in the cycle after edge T0+2N·SCLK_HALF. With defaults that is T0+192.
- busy_out falls CS_GAP cycles after data_valid_out.
- The earliest next request can be accepted on the cycle after busy_out falls.

## Configuration
- `SPI_FLASH_FAST_READ_EN` defined:
  - command byte is 0x0B (FAST READ);
  - 8 dummy SCLK cycles with mosi_out=0 are inserted between ADDR and DATA;
  - N=56.
- Undefined: command byte is 0x03, there is no DUMMY state, and N=48.

## Structure
- Package `spi_flash_pkg` holds:
  - the state enum;
  - CMD_READ=8'h03 and CMD_FAST_READ=8'h0B;
  - field widths CMD_BITS=8, ADDR_BITS=24, DUMMY_BITS=8, DATA_BITS=16.
- One sub-module, `spi_clk_div`, generates the SCLK_HALF phase counter with rise/fall strobes. It runs only while cs_out=0.
- The top level holds the FSM, shift registers and output registers.

## Test plan
- Reset held for 10 cycles, then released → all outputs at their reset values; no SCLK toggles.
- addr_in=0x1234, 1-cycle strobe, flash model returns 0x8086 → MOSI frame 0x03,0x00,0x24,0x68; data_out=0x8086; data_valid_out pulses once at T0+192; busy_out clears 4 cycles later.
- addr_valid_in pulsed again at T0+50 during busy → ignored; exactly one transaction occurs; flash sees exactly 48 SCLK rising edges.
- reset_in low at T0+100 → cs_out=1 and sclk_out=0 immediately; no valid pulse. A new request with addr 0x0001 then reads correctly (address bytes 0x00,0x00,0x02).
- Back-to-back requests for 0xFFFF then 0x0000 → address bytes 0x01,0xFF,0xFE, then 0x00,0x00,0x00; cs_out high ≥4 cycles between the two frames.
- With `SPI_FLASH_FAST_READ_EN`, addr 0x1234 → command 0x0B, 8 dummy clocks, data_out=0x8086 at T0+224.
